// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants: result entry layout and output FIFO geometry
package alu_pkg;

    localparam int ID_SIZE             = 8;
    localparam int DATA_SIZE           = 17;
    localparam int FIFO_OUT_WIDTH      = ID_SIZE + DATA_SIZE;
    localparam int FIFO_OUT_DEPTH      = 8;
    localparam int FIFO_OUT_ADDR_SIZE  = 3;

endpackage

// File: rtl/d_ff_sync_en.sv
// rtl/d_ff_sync_en.sv - enabled register with synchronous active-high reset to RESET_VALUE
module d_ff_sync_en #(
    parameter int              SIZE        = 1,
    parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fifo_out.sv
// rtl/fifo_out.sv - show-ahead result FIFO between the ALU output control unit and the consumer
module fifo_out #(
    parameter int FIFO_OUT_WIDTH = alu_pkg::FIFO_OUT_WIDTH,
    parameter int DEPTH          = alu_pkg::FIFO_OUT_DEPTH,
    parameter int ADDR_SIZE      = alu_pkg::FIFO_OUT_ADDR_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_en_out,
    input  logic [FIFO_OUT_WIDTH-1:0] fifo_res,
    output logic                      ready_f_res,
    input  logic                      r_en,
    output logic                      valid_f_out,
    output logic [FIFO_OUT_WIDTH-1:0] data_out,
    output logic [ADDR_SIZE:0]        count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE+1)'(DEPTH);

    logic [FIFO_OUT_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_SIZE:0] wr_ptr;
    logic [ADDR_SIZE:0] rd_ptr;
    logic [ADDR_SIZE:0] count_next;
    logic               wr_acc;
    logic               rd_acc;
    logic               ovf_set;
    logic               unf_set;
    logic               ready_next;
    logic               valid_next;

    // Acceptance uses the registered flags, so a full/empty FIFO ignores the
    // blocked side even when the other side moves in the same cycle.
    assign wr_acc  = w_en_out && ready_f_res;
    assign rd_acc  = r_en && valid_f_out;
    assign ovf_set = w_en_out && !ready_f_res;
    assign unf_set = r_en && !valid_f_out;

    assign count_next = count + (ADDR_SIZE+1)'(wr_acc) - (ADDR_SIZE+1)'(rd_acc);
    assign ready_next = (count_next != DEPTH_CNT);
    assign valid_next = (count_next != '0);

    d_ff_sync_en #(.SIZE(ADDR_SIZE+1), .RESET_VALUE('0)) u_wr_ptr (
        .clk(clk), .rst(rst), .en(wr_acc),
        .d(wr_ptr + (ADDR_SIZE+1)'(1)), .q(wr_ptr)
    );

    d_ff_sync_en #(.SIZE(ADDR_SIZE+1), .RESET_VALUE('0)) u_rd_ptr (
        .clk(clk), .rst(rst), .en(rd_acc),
        .d(rd_ptr + (ADDR_SIZE+1)'(1)), .q(rd_ptr)
    );

    d_ff_sync_en #(.SIZE(ADDR_SIZE+1), .RESET_VALUE('0)) u_count (
        .clk(clk), .rst(rst), .en(1'b1), .d(count_next), .q(count)
    );

    d_ff_sync_en #(.SIZE(1), .RESET_VALUE(1'b1)) u_ready (
        .clk(clk), .rst(rst), .en(1'b1), .d(ready_next), .q(ready_f_res)
    );

    d_ff_sync_en #(.SIZE(1), .RESET_VALUE(1'b0)) u_valid (
        .clk(clk), .rst(rst), .en(1'b1), .d(valid_next), .q(valid_f_out)
    );

    d_ff_sync_en #(.SIZE(1), .RESET_VALUE(1'b0)) u_overflow (
        .clk(clk), .rst(rst), .en(ovf_set), .d(1'b1), .q(overflow)
    );

    d_ff_sync_en #(.SIZE(1), .RESET_VALUE(1'b0)) u_underflow (
        .clk(clk), .rst(rst), .en(unf_set), .d(1'b1), .q(underflow)
    );

    // Storage is not cleared by reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr[ADDR_SIZE-1:0]] <= fifo_res;
        end
    end

    assign data_out = valid_f_out ? mem[rd_ptr[ADDR_SIZE-1:0]] : '0;

endmodule

// File: tb/tb_fifo_out.sv
// tb/tb_fifo_out.sv - randomized self-checking bench for fifo_out against a queue model
module tb_fifo_out;

    localparam int W     = 25;
    localparam int DEPTH = 8;
    localparam int AS    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en_out;
    logic [W-1:0]  fifo_res;
    logic          ready_f_res;
    logic          r_en;
    logic          valid_f_out;
    logic [W-1:0]  data_out;
    logic [AS:0]   count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fails  = 0;

    logic [W-1:0] model_q [$];
    bit           model_ovf;
    bit           model_unf;

    fifo_out #(.FIFO_OUT_WIDTH(W), .DEPTH(DEPTH), .ADDR_SIZE(AS)) dut (
        .clk(clk), .rst(rst), .w_en_out(w_en_out), .fifo_res(fifo_res),
        .ready_f_res(ready_f_res), .r_en(r_en), .valid_f_out(valid_f_out),
        .data_out(data_out), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string ctx);
        int n;
        n = model_q.size();
        check({ctx, ".count"}, 32'(count), 32'(n));
        check({ctx, ".valid"}, 32'(valid_f_out), 32'(n != 0));
        check({ctx, ".ready"}, 32'(ready_f_res), 32'(n != DEPTH));
        check({ctx, ".data"}, 32'(data_out), (n != 0) ? 32'(model_q[0]) : 32'd0);
        check({ctx, ".ovf"}, 32'(overflow), 32'(model_ovf));
        check({ctx, ".unf"}, 32'(underflow), 32'(model_unf));
    endtask

    // Checks the state left by the previous edge, applies inputs, then advances the model.
    task automatic cycle(input string ctx, input bit w, input logic [W-1:0] d,
                         input bit r, input bit rs);
        bit full, empty;
        check_state(ctx);
        w_en_out = w; fifo_res = d; r_en = r; rst = rs;
        full  = (model_q.size() == DEPTH);
        empty = (model_q.size() == 0);
        @(posedge clk);
        #1;
        if (rs) begin
            model_q.delete();
            model_ovf = 0;
            model_unf = 0;
        end else begin
            if (w && full)  model_ovf = 1;
            if (r && empty) model_unf = 1;
            if (r && !empty) void'(model_q.pop_front());
            if (w && !full)  model_q.push_back(d);
        end
        w_en_out = 0; r_en = 0; rst = 0;
    endtask

    initial begin
        w_en_out = 0; r_en = 0; fifo_res = '0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_q.delete(); model_ovf = 0; model_unf = 0;

        // Reset state and single write/read latency
        check("reset.count", 32'(count), 32'd0);
        check("reset.ready", 32'(ready_f_res), 32'd1);
        cycle("single_w", 1, 25'h0AB1234, 0, 0);
        check("single.valid", 32'(valid_f_out), 32'd1);
        check("single.data", 32'(data_out), 32'h0AB1234);
        cycle("single_r", 0, '0, 1, 0);
        check("single.empty", 32'(count), 32'd0);

        // Fill, overflow, drain in order
        for (int i = 1; i <= DEPTH; i++) cycle("fill", 1, W'(i), 0, 0);
        check("full.count", 32'(count), 32'd8);
        check("full.ready", 32'(ready_f_res), 32'd0);
        cycle("ovf_w", 1, 25'h1FFFFFF, 0, 0);
        check("full.ovf", 32'(overflow), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain.order", 32'(data_out), 32'(i));
            cycle("drain", 0, '0, 1, 0);
        end

        // Full with simultaneous read+write: write dropped
        for (int i = 0; i < DEPTH; i++) cycle("refill", 1, W'(32'h100 + i), 0, 0);
        cycle("full_rw", 1, 25'h0BADBAD, 1, 0);
        check("full_rw.count", 32'(count), 32'd7);

        // Empty with simultaneous read+write: read dropped
        cycle("rst_a", 0, '0, 0, 1);
        cycle("empty_rw", 1, 25'h0012345, 1, 0);
        check("empty_rw.unf", 32'(underflow), 32'd1);
        check("empty_rw.count", 32'(count), 32'd1);
        check("empty_rw.data", 32'(data_out), 32'h0012345);

        // Steady occupancy of 3 across pointer wrap
        cycle("rst_b", 0, '0, 0, 1);
        for (int i = 0; i < 3; i++) cycle("pre3", 1, W'(32'h200 + i), 0, 0);
        for (int i = 0; i < 20; i++) cycle("wrap", 1, W'(32'h300 + i), 1, 0);
        check("wrap.count", 32'(count), 32'd3);

        // Reset with count=5 and a concurrent write
        cycle("rst_c", 0, '0, 0, 1);
        for (int i = 0; i < 5; i++) cycle("pre5", 1, W'($urandom), 0, 0);
        cycle("rst_w", 1, 25'h0155555, 0, 1);
        check("rst_w.count", 32'(count), 32'd0);
        check("rst_w.valid", 32'(valid_f_out), 32'd0);
        check("rst_w.ready", 32'(ready_f_res), 32'd1);

        // Random phases biased toward filling or draining
        for (int ph = 0; ph < 40; ph++) begin
            int wp;
            wp = (ph % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 50; i++) begin
                cycle("rand",
                      ($urandom_range(99) < wp),
                      W'($urandom),
                      ($urandom_range(99) < (105 - wp)),
                      ($urandom_range(299) == 0));
            end
        end

        check_state("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fifo_out.md
FIFO_OUT -- requirements
Module: fifo_out

Interface
REQ-001 SHALL have parameter FIFO_OUT_WIDTH, default 25, meaning entry width (8-bit ID plus result).
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of entries; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_SIZE, default 3, meaning log2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port w_en_out  input  1  write request from the ALU output control unit.
REQ-007 SHALL have port fifo_res  input  FIFO_OUT_WIDTH  write data, captured when a write is accepted.
REQ-008 SHALL have port ready_f_res  output  1  registered not-full flag (write may be accepted).
REQ-009 SHALL have port r_en  input  1  read request from the downstream consumer.
REQ-010 SHALL have port valid_f_out  output  1  registered not-empty flag.
REQ-011 SHALL have port data_out  output  FIFO_OUT_WIDTH  head entry, show-ahead.
REQ-012 SHALL have port count  output  ADDR_SIZE+1  number of stored entries, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky flag: a write was attempted while full.
REQ-014 SHALL have port underflow  output  1  sticky flag: a read was attempted while empty.

Function
REQ-015 SHALL accept a write in a cycle when w_en_out=1 and ready_f_res=1; the entry is stored at wr_ptr and wr_ptr increments.
REQ-016 SHALL accept a read in a cycle when r_en=1 and valid_f_out=1; rd_ptr increments.
REQ-017 SHALL drive data_out combinationally from mem[rd_ptr], so the head entry is visible while valid_f_out=1 with zero read latency.
REQ-018 SHALL drive data_out to all zeros while valid_f_out=0.
REQ-019 SHALL wrap rd_ptr and wr_ptr modulo DEPTH, each carrying an extra wrap bit; full is defined as equal addresses with differing wrap bits, empty as equal pointers.
REQ-020 SHALL register count, ready_f_res and valid_f_out so that they reflect the post-edge occupancy in the cycle after the edge (ready_f_res = count!=DEPTH, valid_f_out = count!=0).
REQ-021 SHALL give a first write into an empty FIFO a write-to-valid_f_out latency of one cycle.
REQ-022 SHALL, on simultaneous accepted read and write, keep count unchanged and advance both pointers.
REQ-023 SHALL, when w_en_out=1 while full, ignore the write even if a read is accepted in the same cycle, leave memory and wr_ptr unchanged, and set overflow.
REQ-024 SHALL, when r_en=1 while empty, ignore the read even if a write is accepted in the same cycle, leave rd_ptr unchanged, and set underflow.
REQ-025 SHALL hold overflow and underflow at 1 until reset.
REQ-026 SHALL never exceed DEPTH or go below 0 in count.

Reset
REQ-027 SHALL, while rst=1 at a rising edge, clear rd_ptr, wr_ptr, count, overflow and underflow to 0, set ready_f_res=1 and set valid_f_out=0.
REQ-028 SHALL give reset priority over any simultaneous read or write; a mid-operation reset discards all stored entries.
REQ-029 SHALL NOT reset the memory array contents; data_out is all zeros after reset per REQ-018.

Structure
REQ-030 SHALL take FIFO_OUT_WIDTH, ID_SIZE and DATA_SIZE from the shared ALU constants package (alu_pkg) so that the ALU, the output control unit and fifo_out agree on the entry layout.
REQ-031 SHALL implement the pointer, count and flag registers with one sub-module, d_ff_sync_en (parameterised SIZE and RESET_VALUE, synchronous active-high reset, enable).
REQ-032 SHALL keep the memory as a single register array inside fifo_out, with no RAM macro.

Verification
REQ-033 SHALL cover: after reset, write 0x0AB1234 -> next cycle valid_f_out=1, count=1, data_out=0x0AB1234; r_en=1 -> next cycle valid_f_out=0, count=0.
REQ-034 SHALL cover: 8 back-to-back writes of 0x0000001..0x0000008 -> ready_f_res=0 and count=8; a 9th write -> overflow=1 and the contents are unchanged; then 8 reads -> data in order 1..8.
REQ-035 SHALL cover: full FIFO with w_en_out=1 and r_en=1 in the same cycle -> read accepted, write dropped, count=7, overflow=1.
REQ-036 SHALL cover: empty FIFO with r_en=1 and w_en_out=1 in the same cycle -> write accepted, underflow=1, count=1, pointers consistent.
REQ-037 SHALL cover: 20 interleaved write/read pairs at count=3 (pointer wrap) -> count stays 3 and FIFO order is preserved across the wrap.
REQ-038 SHALL cover: rst=1 asserted with count=5 and a simultaneous write -> next cycle count=0, valid_f_out=0, ready_f_res=1, flags=0.
